// File: rtl/fod_dither_pkg.sv
// Shared definitions for the DSM dither source: scheduler state encoding and default URN width.
package fod_dither_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEED = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam int URN_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEED = ST_SEED,
    WARM = ST_WARM,
    RUN  = ST_RUN
  } dith_state_t;

endpackage

// File: rtl/rr_arbiter_1hot.sv
// Combinational round-robin pick: first set request at or after (ptr+1) mod NREQ, wrapping upward.
module rr_arbiter_1hot #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [PW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      j = PW'((int'(ptr) + off) % NREQ);
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsm_dither_sched.sv
// Sequences the LFSR dither generator through seed/warm-up/run and hands each URN sample
// to exactly one DSM consumer via round-robin arbitration.
module dsm_dither_sched
  import fod_dither_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WARMUP = 16,
  parameter int UW     = URN_W_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic            reseed,
  input  logic [NREQ-1:0] req,
  input  logic [UW-1:0]   urn_in,
  output logic            lfsr_en,
  output logic [NREQ-1:0] gnt,
  output logic [UW-1:0]   urn_out,
  output logic            urn_vld,
  output logic            ready
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(WARMUP + 1);

  dith_state_t     state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter_1hot #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= PW'(NREQ - 1);
      lfsr_en <= 1'b0;
      gnt     <= '0;
      urn_out <= '0;
      urn_vld <= 1'b0;
      ready   <= 1'b0;
    end else begin
      // Grants are single-cycle pulses; only the RUN arbitration branch re-asserts them.
      gnt     <= '0;
      urn_vld <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        lfsr_en <= 1'b0;
        ready   <= 1'b0;
        urn_out <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= SEED;
            lfsr_en <= 1'b0;
            ready   <= 1'b0;
          end
          SEED: begin
            state   <= WARM;
            cnt     <= '0;
            lfsr_en <= 1'b1;
          end
          WARM: begin
            if (reseed) begin
              state   <= SEED;
              lfsr_en <= 1'b0;
            end else if (cnt == CW'(WARMUP - 1)) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (reseed) begin
              state   <= SEED;
              lfsr_en <= 1'b0;
              ready   <= 1'b0;
            end else if (arb_any) begin
              gnt     <= arb_gnt;
              urn_out <= urn_in;
              urn_vld <= 1'b1;
              ptr     <= arb_idx;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsm_dither_sched.sv
// Directed bench for dsm_dither_sched: sequencing, round-robin grants, reseed, enable drop, async reset.
module tb_dsm_dither_sched;

  localparam int NREQ = 4;
  localparam int WARMUP = 16;
  localparam int UW = 6;

  logic            clk = 1'b0;
  logic            nrst;
  logic            en;
  logic            reseed;
  logic [NREQ-1:0] req;
  logic [UW-1:0]   urn_in;
  logic            lfsr_en;
  logic [NREQ-1:0] gnt;
  logic [UW-1:0]   urn_out;
  logic            urn_vld;
  logic            ready;

  int checks = 0;
  int errors = 0;

  dsm_dither_sched #(.NREQ(NREQ), .WARMUP(WARMUP), .UW(UW)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .reseed  (reseed),
    .req     (req),
    .urn_in  (urn_in),
    .lfsr_en (lfsr_en),
    .gnt     (gnt),
    .urn_out (urn_out),
    .urn_vld (urn_vld),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enable from IDLE and advance to the first RUN cycle (SEED + WARMUP warm cycles + 1).
  task automatic go_run();
    en = 1'b1;
    repeat (WARMUP + 2) step();
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; reseed = 1'b0; req = '0; urn_in = '0;
    #12;
    checks++;
    if ({lfsr_en, gnt, urn_out, urn_vld, ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got lfsr_en=%b gnt=%b urn_out=%h vld=%b ready=%b, required all 0",
               lfsr_en, gnt, urn_out, urn_vld, ready);
    end
    step();
    nrst = 1'b1;
  endtask

  task automatic test_enable_seq();
    en = 1'b1;
    step();
    checks++;
    if (lfsr_en !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL seed_cycle: got lfsr_en=%b ready=%b, required 0 0", lfsr_en, ready);
    end
    for (int c = 2; c <= 17; c++) begin
      step();
      checks++;
      if (lfsr_en !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL warm_cycle%0d: got lfsr_en=%b ready=%b, required 1 0", c, lfsr_en, ready);
      end
    end
    step();
    checks++;
    if (ready !== 1'b1 || lfsr_en !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: got ready=%b lfsr_en=%b, required 1 1", ready, lfsr_en);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      urn_in = UW'(10 + i);
      step();
      exp_g = NREQ'(1) << (i % NREQ);
      checks++;
      if (gnt !== exp_g || urn_out !== UW'(10 + i) || urn_vld !== 1'b1) begin
        errors++;
        $display("FAIL rr_grant%0d: got gnt=%b urn=%h vld=%b, required gnt=%b urn=%h vld=1",
                 i, gnt, urn_out, urn_vld, exp_g, UW'(10 + i));
      end
    end
    req = '0;
    urn_in = 6'h33;
    step();
    checks++;
    if (gnt !== '0 || urn_vld !== 1'b0 || urn_out !== 6'd14) begin
      errors++;
      $display("FAIL rr_idle_hold: got gnt=%b vld=%b urn=%h, required gnt=0 vld=0 urn=0e", gnt, urn_vld, urn_out);
    end
  endtask

  task automatic test_sparse();
    req = 4'b0100; urn_in = 6'h05;
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++; $display("FAIL sparse_lone2: got gnt=%b, required 0100", gnt);
    end
    req = 4'b0101; urn_in = 6'h06;
    step();
    checks++;
    if (gnt !== 4'b0001 || urn_out !== 6'h06) begin
      errors++; $display("FAIL sparse_wrap0: got gnt=%b urn=%h, required 0001 06", gnt, urn_out);
    end
    req = 4'b0100; urn_in = 6'h07;
    step();
    checks++;
    if (gnt !== 4'b0100 || urn_out !== 6'h07) begin
      errors++; $display("FAIL sparse_then2: got gnt=%b urn=%h, required 0100 07", gnt, urn_out);
    end
    req = 4'b0000;
    step();
    req = 4'b1000; urn_in = 6'h3c;
    step();
    req = 4'b0000;
    checks++;
    if (gnt !== 4'b1000 || urn_out !== 6'h3c || urn_vld !== 1'b1) begin
      errors++; $display("FAIL sparse_pulse3: got gnt=%b urn=%h vld=%b, required 1000 3c 1", gnt, urn_out, urn_vld);
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || urn_vld !== 1'b0) begin
      errors++; $display("FAIL sparse_pulse_end: got gnt=%b vld=%b, required 0000 0", gnt, urn_vld);
    end
  endtask

  task automatic test_reseed();
    logic bad;
    req = 4'b0011; urn_in = 6'h11;
    step();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL reseed_pre_grant: got gnt=%b, required 0001", gnt);
    end
    req = 4'b0010; reseed = 1'b1;
    step();
    reseed = 1'b0;
    checks++;
    if (lfsr_en !== 1'b0 || gnt !== '0 || ready !== 1'b0) begin
      errors++; $display("FAIL reseed_seed: got lfsr_en=%b gnt=%b ready=%b, required 0 0000 0", lfsr_en, gnt, ready);
    end
    bad = 1'b0;
    for (int c = 0; c < WARMUP; c++) begin
      step();
      if (lfsr_en !== 1'b1 || gnt !== '0 || ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL reseed_warm: got a warm cycle off lfsr_en=1/gnt=0/ready=0, required none");
    end
    step();
    checks++;
    if (ready !== 1'b1 || gnt !== '0) begin
      errors++; $display("FAIL reseed_rerun: got ready=%b gnt=%b, required 1 0000", ready, gnt);
    end
    urn_in = 6'h22;
    step();
    req = '0;
    checks++;
    if (gnt !== 4'b0010 || urn_out !== 6'h22) begin
      errors++; $display("FAIL reseed_resume: got gnt=%b urn=%h, required 0010 22", gnt, urn_out);
    end
  endtask

  task automatic test_en_drop();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    repeat (8) step();
    en = 1'b0;
    step();
    checks++;
    if (lfsr_en !== 1'b0 || ready !== 1'b0 || gnt !== '0) begin
      errors++; $display("FAIL en_drop_warm: got lfsr_en=%b ready=%b gnt=%b, required 0 0 0000", lfsr_en, ready, gnt);
    end
    en = 1'b1;
    step();
    checks++;
    if (lfsr_en !== 1'b0) begin
      errors++; $display("FAIL reen_seed: got lfsr_en=%b, required 0", lfsr_en);
    end
    for (int c = 0; c < WARMUP; c++) begin
      step();
      checks++;
      if (lfsr_en !== 1'b1 || ready !== 1'b0) begin
        errors++; $display("FAIL reen_warm%0d: got lfsr_en=%b ready=%b, required 1 0", c, lfsr_en, ready);
      end
    end
    step();
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL reen_run: got ready=%b, required 1", ready);
    end
    req = 4'b0001; urn_in = 6'h2a;
    step();
    checks++;
    if (gnt !== 4'b0001 || urn_out !== 6'h2a) begin
      errors++; $display("FAIL en_pre_grant: got gnt=%b urn=%h, required 0001 2a", gnt, urn_out);
    end
    req = 4'b0100; en = 1'b0;
    step();
    checks++;
    if ({lfsr_en, gnt, urn_out, urn_vld, ready} !== '0) begin
      errors++;
      $display("FAIL en_drop_run: got lfsr_en=%b gnt=%b urn=%h vld=%b ready=%b, required all 0",
               lfsr_en, gnt, urn_out, urn_vld, ready);
    end
    req = '0;
  endtask

  task automatic test_async_reset();
    go_run();
    req = 4'b0100; urn_in = 6'h19;
    step();
    checks++;
    if (gnt !== 4'b0100 || urn_vld !== 1'b1) begin
      errors++; $display("FAIL ar_pre_grant: got gnt=%b vld=%b, required 0100 1", gnt, urn_vld);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({lfsr_en, gnt, urn_out, urn_vld, ready} !== '0) begin
      errors++;
      $display("FAIL ar_immediate: got lfsr_en=%b gnt=%b urn=%h vld=%b ready=%b, required all 0",
               lfsr_en, gnt, urn_out, urn_vld, ready);
    end
    req = '0; en = 1'b0;
    #3 nrst = 1'b1;
    step();
    go_run();
    req = 4'b1111; urn_in = 6'h01;
    step();
    req = '0;
    checks++;
    if (gnt !== 4'b0001 || urn_out !== 6'h01) begin
      errors++; $display("FAIL ar_ptr_reset: got gnt=%b urn=%h, required 0001 01", gnt, urn_out);
    end
  endtask

  initial begin
    test_reset();
    test_enable_seq();
    test_round_robin();
    test_sparse();
    test_reseed();
    test_en_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
